btn_debounce_pulse: RTL and testbench

Multi-channel button conditioner that sits directly upstream of the ALU interface top level: it takes raw, asynchronous, bouncing push-button inputs and produces clean synchronous levels plus single-cycle press pulses. Those pulses drive the operand-1, operand-2 and operator load strobes, so one physical press loads exactly one value. Each channel is independent: a 2-FF synchronizer, a debounce counter and a rising-edge one-shot.

---
 rtl/btn_debounce_pulse.sv | 53 +++++
 tb/tb_btn_debounce_pulse.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: per-channel 2-FF synchronizer, debounce counter and press one-shot
//   i_clk    system clock, all state on rising edge
//   i_reset  asynchronous active-low reset
//   i_btn    raw asynchronous button levels (active-high)
//   o_level  debounced level per channel
//   o_pulse  registered one-cycle pulse on each accepted 0->1
// Build option: define BTN_ONEHOT_GUARD_EN to keep o_pulse one-hot or zero
// (lowest-index channel wins when several presses are accepted together).
module btn_debounce_pulse #(
    parameter int NB_BTN          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_COUNT        = 20
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_level,
    output logic [NB_BTN-1:0] o_pulse
);
    localparam logic [NB_COUNT-1:0] TERM = NB_COUNT'(DEBOUNCE_CYCLES - 1);
    logic [NB_BTN-1:0]   sync1, sync2, done, rise, pulse_next;
    logic [NB_COUNT-1:0] cnt [NB_BTN];
    // done: the differing level has been seen long enough and is accepted this edge
    always_comb begin
        done = '0;
        for (int k = 0; k < NB_BTN; k++)
            done[k] = (sync2[k] != o_level[k]) && (cnt[k] == TERM);
        rise = done & sync2;
`ifdef BTN_ONEHOT_GUARD_EN
        // x & -x isolates the lowest set bit
        pulse_next = rise & (~rise + NB_BTN'(1));
`else
        pulse_next = rise;
`endif
    end
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1   <= '0;
            sync2   <= '0;
            o_level <= '0;
            o_pulse <= '0;
            for (int k = 0; k < NB_BTN; k++)
                cnt[k] <= '0;
        end else begin
            sync1   <= i_btn;
            sync2   <= sync1;
            o_level <= o_level ^ done;
            o_pulse <= pulse_next;
            for (int k = 0; k < NB_BTN; k++)
                cnt[k] <= (sync2[k] == o_level[k] || done[k]) ? '0 : cnt[k] + NB_COUNT'(1);
        end
    end
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: randomized and directed checks against a sliding-window reference model
module tb_btn_debounce_pulse;
    localparam int NB  = 3;
    localparam int DEB = 4;
`ifdef BTN_ONEHOT_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] level, pulse;
    int            errs = 0;
    int            checks = 0;

    btn_debounce_pulse #(.NB_BTN(NB), .DEBOUNCE_CYCLES(DEB), .NB_COUNT(3)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_btn(btn), .o_level(level), .o_pulse(pulse)
    );

    always #5 clk = ~clk;

    // Reference: sync2 is the input seen two edges earlier; a level is accepted
    // once the last DEB sync2 samples all disagree with the current level.
    logic [NB-1:0] m_s1, m_s2, m_level, m_pulse, flip, m_next_pulse;
    logic [NB-1:0] win [DEB-1];
    always_comb begin
        flip = '0;
        m_next_pulse = '0;
        for (int k = 0; k < NB; k++) begin
            flip[k] = (m_s2[k] != m_level[k]);
            for (int j = 0; j < DEB - 1; j++)
                if (win[j][k] == m_level[k]) flip[k] = 1'b0;
        end
        for (int k = 0; k < NB; k++)
            if (flip[k] && !m_level[k] && !(GUARD && m_next_pulse != '0)) m_next_pulse[k] = 1'b1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0;
            m_s2 <= '0;
            m_level <= '0;
            m_pulse <= '0;
            for (int j = 0; j < DEB - 1; j++) win[j] <= '0;
        end else begin
            m_s1 <= btn;
            m_s2 <= m_s1;
            win[0] <= m_s2;
            for (int j = 1; j < DEB - 1; j++) win[j] <= win[j-1];
            m_level <= m_level ^ flip;
            m_pulse <= m_next_pulse;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        btn = '0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn = '0;
        #1;
        checks++;
        if (level !== 3'b000 || pulse !== 3'b000) begin
            errs++;
            $display("FAIL reset: level=%b pulse=%b expected 000/000", level, pulse);
        end
        tick();
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_clean_press();
        btn = 3'b001;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if (pulse !== (n == 6 ? 3'b001 : 3'b000) || level !== (n >= 6 ? 3'b001 : 3'b000)) begin
                errs++;
                $display("FAIL clean_press t=%0d: level=%b pulse=%b", n, level, pulse);
            end
            checks++;
            if (level !== m_level || pulse !== m_pulse) begin
                errs++;
                $display("FAIL clean_press_model t=%0d: got %b/%b want %b/%b", n, level, pulse, m_level, m_pulse);
            end
        end
        btn = 3'b000;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (pulse !== 3'b000 || level !== (n >= 6 ? 3'b000 : 3'b001)) begin
                errs++;
                $display("FAIL clean_release t=%0d: level=%b pulse=%b", n, level, pulse);
            end
        end
        settle();
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        int np;
        pat = 8'b0011_0011;
        np = 0;
        for (int n = 1; n <= 24; n++) begin
            btn = (n <= 8) ? {1'b0, pat[n-1], 1'b0} : 3'b010;
            tick();
            np += int'(pulse[1]);
            checks++;
            if (pulse !== (n == 14 ? 3'b010 : 3'b000) || level !== (n >= 14 ? 3'b010 : 3'b000)) begin
                errs++;
                $display("FAIL bounce t=%0d: level=%b pulse=%b", n, level, pulse);
            end
        end
        checks++;
        if (np != 1) begin
            errs++;
            $display("FAIL bounce_count: pulses=%0d expected 1", np);
        end
        settle();
        settle();
    endtask

    task automatic test_glitch();
        for (int n = 1; n <= 14; n++) begin
            btn = (n <= 3) ? 3'b100 : 3'b000;
            tick();
            checks++;
            if (pulse !== 3'b000 || level !== 3'b000) begin
                errs++;
                $display("FAIL glitch t=%0d: level=%b pulse=%b", n, level, pulse);
            end
        end
    endtask

    task automatic test_simultaneous();
        btn = 3'b110;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (pulse !== (n == 6 ? (GUARD ? 3'b010 : 3'b110) : 3'b000) ||
                level !== (n >= 6 ? 3'b110 : 3'b000)) begin
                errs++;
                $display("FAIL simultaneous t=%0d: level=%b pulse=%b", n, level, pulse);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_count();
        btn = 3'b001;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 3'b000 || pulse !== 3'b000) begin
            errs++;
            $display("FAIL reset_mid: level=%b pulse=%b expected 000/000", level, pulse);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (pulse !== (n == 6 ? 3'b001 : 3'b000) || level !== (n >= 6 ? 3'b001 : 3'b000)) begin
                errs++;
                $display("FAIL reset_mid_after t=%0d: level=%b pulse=%b", n, level, pulse);
            end
        end
        settle();
    endtask

    task automatic test_held_through_reset();
        rst_n = 1'b0;
        btn = 3'b111;
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (pulse !== (n == 6 ? (GUARD ? 3'b001 : 3'b111) : 3'b000) ||
                level !== (n >= 6 ? 3'b111 : 3'b000)) begin
                errs++;
                $display("FAIL held_reset t=%0d: level=%b pulse=%b", n, level, pulse);
            end
        end
        settle();
    endtask

    task automatic test_random();
        logic [NB-1:0] prev;
        int left;
        prev = '0;
        left = 0;
        for (int n = 0; n < 600; n++) begin
            if (left == 0) begin
                btn = NB'($urandom_range(0, 7));
                left = $urandom_range(1, 8);
            end
            left--;
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
            checks++;
            if (level !== m_level || pulse !== m_pulse) begin
                errs++;
                $display("FAIL random t=%0d: got %b/%b want %b/%b", n, level, pulse, m_level, m_pulse);
            end
            checks++;
            if ((prev & pulse) != '0) begin
                errs++;
                $display("FAIL random_consecutive t=%0d: prev=%b pulse=%b", n, prev, pulse);
            end
            prev = pulse;
        end
        rst_n = 1'b1;
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        test_held_through_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
